board_reset_sequencer: RTL and testbench



---
 rtl/board_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_board_reset_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/board_reset_sequencer.sv
// Board reset conditioning: button synchronizer/debouncer, power-on hold,
// SoC and peripheral reset release sequencing, reset cause and press counter.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// POR_HOLD    | power-on hold; SoC and peripheral resets asserted
// BTN_HOLD    | button reset; stretch runs once the button is released
// PERIPH_WAIT | SoC released, peripheral reset still asserted
// RUN         | both resets released
module board_reset_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int POR_CYCLES      = 1024,
    parameter int STRETCH_CYCLES  = 256,
    parameter int PERIPH_DELAY    = 64
) (
    input  logic       ref_clk,
    input  logic       ref_rst,
    input  logic       btn_reset_ni,
    output logic       soc_rst_no,
    output logic       periph_rst_no,
    output logic [1:0] rst_cause_o,
    output logic [7:0] rst_count_o,
    output logic       busy_o
);

    localparam int HOLD_MAX_A = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
    localparam int HOLD_MAX   = (HOLD_MAX_A > PERIPH_DELAY) ? HOLD_MAX_A : PERIPH_DELAY;
    localparam int HOLD_W     = $clog2(HOLD_MAX) + 1;
    localparam int DB_W       = $clog2(DEBOUNCE_CYCLES);

    localparam logic [HOLD_W-1:0] POR_LAST     = HOLD_W'(POR_CYCLES);
    localparam logic [HOLD_W-1:0] STRETCH_LAST = HOLD_W'(STRETCH_CYCLES);
    localparam logic [HOLD_W-1:0] PERIPH_LAST  = HOLD_W'(PERIPH_DELAY);
    localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] POR_HOLD    = 2'd0;
    localparam logic [1:0] BTN_HOLD    = 2'd1;
    localparam logic [1:0] PERIPH_WAIT = 2'd2;
    localparam logic [1:0] RUN         = 2'd3;

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_BTN = 2'b10;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   deb;
    logic [DB_W-1:0]        db_cnt;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [1:0]        cause_nxt;
    logic [7:0]        count_nxt;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge ref_clk or posedge ref_rst) begin
        if (ref_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_reset_ni};
        end
    end

    // A level change is accepted only after it persists for the full window.
    always_ff @(posedge ref_clk or posedge ref_rst) begin
        if (ref_rst) begin
            deb    <= 1'b1;
            db_cnt <= '0;
        end else if (sync_lvl == deb) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            deb    <= sync_lvl;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        cause_nxt = rst_cause_o;
        count_nxt = rst_count_o;
        case (state)
            POR_HOLD: begin
                if (hold_cnt == POR_LAST && deb) begin
                    state_nxt = PERIPH_WAIT;
                    hold_nxt  = '0;
                end else if (hold_cnt != POR_LAST) begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            BTN_HOLD: begin
                if (!deb) begin
                    hold_nxt = '0;
                end else if (hold_cnt == STRETCH_LAST) begin
                    state_nxt = PERIPH_WAIT;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            PERIPH_WAIT, RUN: begin
                // deb is always 1 on entry to these states, so a low level is a new press
                if (!deb) begin
                    state_nxt = BTN_HOLD;
                    hold_nxt  = '0;
                    cause_nxt = CAUSE_BTN;
                    count_nxt = (rst_count_o == 8'hFF) ? rst_count_o : rst_count_o + 8'd1;
                end else if (state == PERIPH_WAIT) begin
                    if (hold_cnt == PERIPH_LAST) begin
                        state_nxt = RUN;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = POR_HOLD;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge ref_clk or posedge ref_rst) begin
        if (ref_rst) begin
            state         <= POR_HOLD;
            hold_cnt      <= '0;
            rst_cause_o   <= CAUSE_POR;
            rst_count_o   <= 8'd0;
            soc_rst_no    <= 1'b0;
            periph_rst_no <= 1'b0;
            busy_o        <= 1'b1;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_nxt;
            rst_cause_o   <= cause_nxt;
            rst_count_o   <= count_nxt;
            soc_rst_no    <= (state_nxt == PERIPH_WAIT) || (state_nxt == RUN);
            periph_rst_no <= (state_nxt == RUN);
            busy_o        <= (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Directed bench for board_reset_sequencer with short debounce/hold parameters;
// expected edge counts are worked out by hand from the timing rules.
module tb_board_reset_sequencer;

    logic       ref_clk = 1'b0;
    logic       ref_rst;
    logic       btn_reset_ni;
    logic       soc_rst_no;
    logic       periph_rst_no;
    logic [1:0] rst_cause_o;
    logic [7:0] rst_count_o;
    logic       busy_o;

    int tests = 0;
    int fails = 0;

    board_reset_sequencer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .POR_CYCLES     (16),
        .STRETCH_CYCLES (8),
        .PERIPH_DELAY   (4)
    ) dut (
        .ref_clk      (ref_clk),
        .ref_rst      (ref_rst),
        .btn_reset_ni (btn_reset_ni),
        .soc_rst_no   (soc_rst_no),
        .periph_rst_no(periph_rst_no),
        .rst_cause_o  (rst_cause_o),
        .rst_count_o  (rst_count_o),
        .busy_o       (busy_o)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, busy_o}, 8'd0);
    endtask

    task automatic full_press();
        btn_reset_ni = 1'b0;
        repeat (7) tick();
        btn_reset_ni = 1'b1;
        wait_run("press_run");
    endtask

    initial begin
        ref_rst      = 1'b1;
        btn_reset_ni = 1'b1;

        repeat (3) tick();
        chk("rst_soc",    {7'd0, soc_rst_no},    8'd0);
        chk("rst_periph", {7'd0, periph_rst_no}, 8'd0);
        chk("rst_cause",  {6'd0, rst_cause_o},   8'd1);
        chk("rst_count",  rst_count_o,           8'd0);
        chk("rst_busy",   {7'd0, busy_o},        8'd1);

        // power-on: next edge is edge 1
        ref_rst = 1'b0;
        repeat (16) tick();
        chk("por_soc_e16", {7'd0, soc_rst_no}, 8'd0);
        tick();
        chk("por_soc_e17",    {7'd0, soc_rst_no},    8'd1);
        chk("por_periph_e17", {7'd0, periph_rst_no}, 8'd0);
        chk("por_busy_e17",   {7'd0, busy_o},        8'd1);
        repeat (4) tick();
        chk("por_periph_e21", {7'd0, periph_rst_no}, 8'd0);
        chk("por_busy_e21",   {7'd0, busy_o},        8'd1);
        tick();
        chk("por_periph_e22", {7'd0, periph_rst_no}, 8'd1);
        chk("por_busy_e22",   {7'd0, busy_o},        8'd0);
        chk("por_cause",      {6'd0, rst_cause_o},   8'd1);
        chk("por_count",      rst_count_o,           8'd0);

        // glitches of 1..3 cycles must be ignored
        for (int k = 1; k <= 3; k++) begin
            btn_reset_ni = 1'b0;
            repeat (k) tick();
            btn_reset_ni = 1'b1;
            for (int j = 0; j < 10; j++) begin
                tick();
                chk("glitch_soc",    {7'd0, soc_rst_no},    8'd1);
                chk("glitch_periph", {7'd0, periph_rst_no}, 8'd1);
            end
            chk("glitch_count", rst_count_o, 8'd0);
        end

        // clean press: resets fall after press edge 6, held 20 cycles
        btn_reset_ni = 1'b0;
        repeat (6) tick();
        chk("press_soc_e5", {7'd0, soc_rst_no}, 8'd1);
        tick();
        chk("press_soc_e6",    {7'd0, soc_rst_no},    8'd0);
        chk("press_periph_e6", {7'd0, periph_rst_no}, 8'd0);
        chk("press_cause",     {6'd0, rst_cause_o},   8'd2);
        chk("press_count",     rst_count_o,           8'd1);
        repeat (13) tick();
        btn_reset_ni = 1'b1;
        repeat (14) tick();
        chk("rel_soc_e13", {7'd0, soc_rst_no}, 8'd0);
        tick();
        chk("rel_soc_e14",    {7'd0, soc_rst_no},    8'd1);
        chk("rel_periph_e14", {7'd0, periph_rst_no}, 8'd0);
        repeat (4) tick();
        chk("rel_periph_e18", {7'd0, periph_rst_no}, 8'd0);
        tick();
        chk("rel_periph_e19", {7'd0, periph_rst_no}, 8'd1);
        chk("rel_busy_e19",   {7'd0, busy_o},        8'd0);
        chk("rel_count",      rst_count_o,           8'd1);

        // button held through power-on release
        ref_rst      = 1'b1;
        btn_reset_ni = 1'b0;
        repeat (3) tick();
        ref_rst = 1'b0;
        repeat (40) tick();
        chk("held_soc",   {7'd0, soc_rst_no},  8'd0);
        chk("held_cause", {6'd0, rst_cause_o}, 8'd1);
        chk("held_count", rst_count_o,         8'd0);
        btn_reset_ni = 1'b1;
        repeat (6) tick();
        chk("held_soc_e46", {7'd0, soc_rst_no}, 8'd0);
        tick();
        chk("held_soc_e47", {7'd0, soc_rst_no},  8'd1);
        chk("held_cause2",  {6'd0, rst_cause_o}, 8'd1);
        wait_run("held_run");
        chk("held_count2", rst_count_o, 8'd0);

        // re-press during the stretch restarts it without counting
        btn_reset_ni = 1'b0;
        repeat (10) tick();
        chk("rp_count1", rst_count_o, 8'd1);
        btn_reset_ni = 1'b1;
        repeat (6) tick();
        btn_reset_ni = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("rp_soc_hold", {7'd0, soc_rst_no}, 8'd0);
        end
        chk("rp_count_same", rst_count_o, 8'd1);
        btn_reset_ni = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("rp_soc_stretch", {7'd0, soc_rst_no}, 8'd0);
        end
        // press lands during PERIPH_WAIT
        btn_reset_ni = 1'b0;
        repeat (4) tick();
        chk("pw_soc_e13", {7'd0, soc_rst_no}, 8'd0);
        tick();
        chk("pw_soc_e14", {7'd0, soc_rst_no}, 8'd1);
        tick();
        chk("pw_soc_e15",    {7'd0, soc_rst_no},    8'd1);
        chk("pw_periph_e15", {7'd0, periph_rst_no}, 8'd0);
        tick();
        chk("pw_soc_e16", {7'd0, soc_rst_no},  8'd0);
        chk("pw_count",   rst_count_o,         8'd2);
        chk("pw_cause",   {6'd0, rst_cause_o}, 8'd2);
        repeat (3) tick();
        btn_reset_ni = 1'b1;
        wait_run("pw_run");

        // saturation
        for (int i = 0; i < 260; i++) begin
            int e;
            full_press();
            e = (i + 3 > 255) ? 255 : i + 3;
            chk("sat_count", rst_count_o, 8'(e));
        end

        // mid-operation reset during BTN_HOLD with count 3
        ref_rst = 1'b1;
        tick();
        ref_rst = 1'b0;
        wait_run("mid_por_run");
        full_press();
        full_press();
        btn_reset_ni = 1'b0;
        repeat (7) tick();
        chk("mid_count_pre", rst_count_o,         8'd3);
        chk("mid_cause_pre", {6'd0, rst_cause_o}, 8'd2);
        #2;
        ref_rst = 1'b1;
        #1;
        chk("mid_soc",    {7'd0, soc_rst_no},    8'd0);
        chk("mid_periph", {7'd0, periph_rst_no}, 8'd0);
        chk("mid_cause",  {6'd0, rst_cause_o},   8'd1);
        chk("mid_count",  rst_count_o,           8'd0);
        chk("mid_busy",   {7'd0, busy_o},        8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
